flow_action_exec: RTL and testbench
===================================

// Module: flow_action_exec
// PURPOSE
//  Downstream stage of the fixed flow matcher. Consumes the lookup result (is_match + 12-byte flow value) and the
//  packet header, applies the flow's actions (dst-MAC rewrite, IPv4 TTL decrement + incremental checksum,
//  egress-port select, drop), and hands the edited header plus a forwarding verdict to the deparser/egress logic.
//  Keeps hit/miss/drop statistics counters.
// PARAMETERS
//  DEFAULT_PORT  8'h00  egress port used on a table miss
//  MISS_TO_CPU   1'b1   1: a miss is punted to the CPU (to_cpu_o=1); 0: a miss is forwarded to DEFAULT_PORT
//  CNT_W         32     width of each statistics counter
// PORTS
//  clk            in   1                       clock
//  rst            in   1                       synchronous reset, active high
//  start_i        in   1                       1-cycle pulse: inputs valid (driven by matcher ready_o)
//  is_match_i     in   1                       lookup hit
//  flow_val_i     in   `BYTE_BUS x MAX_VAL_LEN  flow value: [0]=opcode, [1]=egress port, [2..7]=new dst MAC, [8..11]=reserved
//  pkt_hdr_i      in   `BYTE_BUS x HDR_MAX_LEN  parsed header bytes (Ethernet at byte 0, IPv4 at byte 14)
//  ready_o        out  1                       1-cycle pulse: outputs valid
//  pkt_hdr_o      out  `BYTE_BUS x HDR_MAX_LEN  edited header
//  egress_port_o  out  8                       chosen egress port
//  drop_o         out  1                       drop the packet
//  to_cpu_o       out  1                       punt the packet to the CPU
//  hit_cnt_o / miss_cnt_o / drop_cnt_o  out  CNT_W  statistics, wrap modulo 2^CNT_W
// BEHAVIOUR
//  Reset: ready_o=0, drop_o=0, to_cpu_o=0, egress_port_o=0, pkt_hdr_o all 0, counters 0, state FREE.
//  Opcode bits: b0 REWRITE_DMAC, b1 DEC_TTL, b2 DROP, b3 SET_PORT; b7..b4 ignored.
//  FSM FREE->DECODE->REWRITE->CSUM->FREE. ready_o pulses exactly 4 cycles after the cycle start_i is sampled.
//   FREE: on start_i, latch is_match_i, flow_val_i and pkt_hdr_i; clear ready_o. Otherwise ready_o <= 0.
//   DECODE: ipv4 = (hdr[12],hdr[13])==16'h0800. Miss: egress=DEFAULT_PORT, to_cpu=MISS_TO_CPU, no edits.
//    Hit: egress = SET_PORT ? val[1] : DEFAULT_PORT; drop = DROP bit.
//   REWRITE (hit, !drop): REWRITE_DMAC -> hdr[0..5]=val[2..7]. DEC_TTL && ipv4: TTL=hdr[22].
//    TTL<=1 -> to_cpu=1, TTL/checksum left unchanged; otherwise hdr[22]=TTL-1.
//   CSUM: if TTL was decremented, checksum {hdr[24],hdr[25]} updated per RFC1624 eqn 3:
//    HC' = ~(~HC + ~m + m') with 16-bit ones'-complement (end-around carry) adds, m={oldTTL,hdr[23]},
//    m'={newTTL,hdr[23]}. Drives pkt_hdr_o/egress/drop/to_cpu, pulses ready_o, bumps exactly one counter:
//    drop -> drop_cnt (drop wins, to_cpu forced 0); else hit -> hit_cnt; miss -> miss_cnt.
//  Outputs hold until the next accepted start_i. start_i outside FREE is ignored (no queueing, no counter change).
//  start_i in the same cycle as ready_o is accepted (state is FREE then).
//  Drop with other opcode bits: header passes through unedited.
//  rst mid-operation: abort, no ready_o, all outputs/counters return to reset values.
//  Bytes outside 0..5, 22, 24..25 are never modified.
// STRUCTURE
//  Opcode bit positions, header offsets (ETH_TYPE=12, IP_TTL=22, IP_PROTO=23, IP_CSUM=24) and ETHERTYPE_IPV4 go
//  into def.svh beside MAX_VAL_LEN/HDR_MAX_LEN so the controller writing flow values shares them.
//  One sub-module: ipv4_csum_incr (combinational, old HC/m/m' -> HC'), reused later by other header-edit stages.
// TESTING
//  1 Hit, opcode 8'h0B, val[1]=8'h05, MAC 02:00:00:00:00:AA, IPv4 TTL 8'h40 proto 8'h11 csum 16'hB861 ->
//    ready 4 cycles later, dmac rewritten, TTL 8'h3F, csum 16'hB961, egress 5, drop=0, to_cpu=0, hit_cnt=1
//  2 Miss, MISS_TO_CPU=1, DEFAULT_PORT=8'h00 -> header unchanged, egress 0, to_cpu=1, miss_cnt=1
//  3 Hit, opcode 8'h02, TTL 8'h01 -> TTL/csum unchanged, to_cpu=1, hit_cnt++; opcode 8'h06 -> drop=1, to_cpu=0,
//    drop_cnt=1
//  4 Hit, opcode 8'h02, ethertype 16'h86DD -> header unchanged, to_cpu=0; csum edge HC=16'hFEFF TTL 8'h02 -> HC'
//    per eqn 3
//  5 start_i at cycle 0 and 2 -> one ready_o at cycle 4, second ignored; start_i on ready_o cycle -> ready_o 4 later
//  6 rst in REWRITE -> no ready_o, outputs/counters 0; next start_i processed normally; counter wrap at CNT_W=4

Source files
------------

// File: rtl/flow_action_exec_pkg.sv
// Shared definitions for the flow action executor. The flow-value layout,
// the opcode bit positions and the header offsets live here so that the
// controller software model and other header-edit stages use the same map.
package flow_action_exec_pkg;

    localparam int unsigned BYTE_BUS    = 8;
    localparam int unsigned MAX_VAL_LEN = 12;
    localparam int unsigned HDR_MAX_LEN = 34;
    localparam int unsigned VAL_W       = BYTE_BUS * MAX_VAL_LEN;
    localparam int unsigned HDR_W       = BYTE_BUS * HDR_MAX_LEN;

    // Flow value byte layout; bytes 8..11 are reserved
    localparam int unsigned VAL_OPCODE  = 0;
    localparam int unsigned VAL_PORT    = 1;
    localparam int unsigned VAL_DMAC    = 2;
    localparam int unsigned VAL_USED    = 8;

    // Opcode bit positions (bits 7..4 are ignored)
    localparam int unsigned OP_REWRITE_DMAC = 0;
    localparam int unsigned OP_DEC_TTL      = 1;
    localparam int unsigned OP_DROP         = 2;
    localparam int unsigned OP_SET_PORT     = 3;

    // Header byte offsets (Ethernet at 0, IPv4 at 14)
    localparam int unsigned HDR_ETH_DMAC = 0;
    localparam int unsigned MAC_LEN      = 6;
    localparam int unsigned ETH_TYPE     = 12;
    localparam int unsigned IP_TTL       = 22;
    localparam int unsigned IP_PROTO     = 23;
    localparam int unsigned IP_CSUM      = 24;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

    typedef enum logic [1:0] {
        ST_FREE,
        ST_DECODE,
        ST_REWRITE,
        ST_CSUM
    } fae_state_t;

    // 16-bit ones'-complement add with end-around carry
    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[15:0] + {15'b0, sum[16]};
    endfunction

endpackage

// File: rtl/flow_action_exec_ipv4_csum_incr.sv
// Incremental IPv4 header checksum update (RFC 1624 eqn 3):
//   HC' = ~(~HC + ~m + m') using ones'-complement arithmetic.
// Purely combinational so other header-edit stages can reuse it.
module ipv4_csum_incr
    import flow_action_exec_pkg::*;
(
    input  logic [15:0] old_csum,
    input  logic [15:0] old_word,
    input  logic [15:0] new_word,
    output logic [15:0] new_csum
);

    logic [15:0] partial;

    assign partial  = ones_add16(~old_csum, ~old_word);
    assign new_csum = ~ones_add16(partial, new_word);

endmodule

// File: rtl/flow_action_exec.sv
// Flow action executor: takes a lookup result plus the parsed header, applies
// the flow's actions (dst-MAC rewrite, TTL decrement with incremental
// checksum, egress select, drop) and presents the edited header with a
// forwarding verdict. Keeps hit/miss/drop statistics.
module flow_action_exec
    import flow_action_exec_pkg::*;
#(
    parameter logic [7:0]  DEFAULT_PORT = 8'h00,
    parameter logic        MISS_TO_CPU  = 1'b1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             is_match_i,
    input  logic [VAL_W-1:0] flow_val_i,
    input  logic [HDR_W-1:0] pkt_hdr_i,
    output logic             ready_o,
    output logic [HDR_W-1:0] pkt_hdr_o,
    output logic [7:0]       egress_port_o,
    output logic             drop_o,
    output logic             to_cpu_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned VAL_USED_W = VAL_USED * BYTE_BUS;

    fae_state_t state_q, state_d;

    // Working registers for the transaction in flight
    logic                  hit_q,     hit_d;
    logic [VAL_USED_W-1:0] val_q,     val_d;
    logic [HDR_W-1:0]      work_q,    work_d;
    logic                  ipv4_q,    ipv4_d;
    logic [7:0]            egress_q,  egress_d;
    logic                  drop_q,    drop_d;
    logic                  cpu_q,     cpu_d;
    logic                  ttl_dec_q, ttl_dec_d;
    logic [7:0]            old_ttl_q, old_ttl_d;

    // Next values of the registered outputs
    logic                  ready_d;
    logic [HDR_W-1:0]      hdr_out_d;
    logic [7:0]            egress_out_d;
    logic                  drop_out_d;
    logic                  cpu_out_d;
    logic [CNT_W-1:0]      hit_cnt_d, miss_cnt_d, drop_cnt_d;

    logic [7:0]            opcode;
    logic [7:0]            ttl;
    logic [7:0]            proto;
    logic [15:0]           ethertype;
    logic [15:0]           csum_old;
    logic [15:0]           csum_new;
    logic                  unused_bits;

    function automatic logic [7:0] hdr_byte(input logic [HDR_W-1:0] h, input int unsigned idx);
        return h[idx*BYTE_BUS +: BYTE_BUS];
    endfunction

    assign opcode    = val_q[VAL_OPCODE*BYTE_BUS +: BYTE_BUS];
    assign ttl       = hdr_byte(work_q, IP_TTL);
    assign proto     = hdr_byte(work_q, IP_PROTO);
    assign ethertype = {hdr_byte(work_q, ETH_TYPE), hdr_byte(work_q, ETH_TYPE + 1)};
    assign csum_old  = {hdr_byte(work_q, IP_CSUM), hdr_byte(work_q, IP_CSUM + 1)};

    // Reserved flow-value bytes and the ignored opcode bits carry no meaning here
    assign unused_bits = ^{flow_val_i[VAL_W-1:VAL_USED_W], opcode[7:4]};

    // By the checksum step the TTL byte already holds the decremented value
    ipv4_csum_incr u_csum (
        .old_csum (csum_old),
        .old_word ({old_ttl_q, proto}),
        .new_word ({ttl, proto}),
        .new_csum (csum_new)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fixed four-step walk, leaving FREE only on start_i
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FREE:    if (start_i) state_d = ST_DECODE;
            ST_DECODE:  state_d = ST_REWRITE;
            ST_REWRITE: state_d = ST_CSUM;
            ST_CSUM:    state_d = ST_FREE;
            default:    state_d = ST_FREE;
        endcase
    end

    // Per-state datapath and output updates
    always_comb begin
        hit_d        = hit_q;
        val_d        = val_q;
        work_d       = work_q;
        ipv4_d       = ipv4_q;
        egress_d     = egress_q;
        drop_d       = drop_q;
        cpu_d        = cpu_q;
        ttl_dec_d    = ttl_dec_q;
        old_ttl_d    = old_ttl_q;
        ready_d      = 1'b0;
        hdr_out_d    = pkt_hdr_o;
        egress_out_d = egress_port_o;
        drop_out_d   = drop_o;
        cpu_out_d    = to_cpu_o;
        hit_cnt_d    = hit_cnt_o;
        miss_cnt_d   = miss_cnt_o;
        drop_cnt_d   = drop_cnt_o;

        case (state_q)
            ST_FREE: begin
                if (start_i) begin
                    hit_d     = is_match_i;
                    val_d     = flow_val_i[VAL_USED_W-1:0];
                    work_d    = pkt_hdr_i;
                    drop_d    = 1'b0;
                    cpu_d     = 1'b0;
                    ttl_dec_d = 1'b0;
                end
            end
            ST_DECODE: begin
                ipv4_d = (ethertype == ETHERTYPE_IPV4);
                if (!hit_q) begin
                    egress_d = DEFAULT_PORT;
                    cpu_d    = MISS_TO_CPU;
                    drop_d   = 1'b0;
                end else begin
                    egress_d = opcode[OP_SET_PORT] ? val_q[VAL_PORT*BYTE_BUS +: BYTE_BUS]
                                                   : DEFAULT_PORT;
                    drop_d   = opcode[OP_DROP];
                    cpu_d    = 1'b0;
                end
            end
            ST_REWRITE: begin
                if (hit_q && !drop_q) begin
                    if (opcode[OP_REWRITE_DMAC]) begin
                        for (int unsigned i = 0; i < MAC_LEN; i++) begin
                            work_d[(HDR_ETH_DMAC + i)*BYTE_BUS +: BYTE_BUS] =
                                val_q[(VAL_DMAC + i)*BYTE_BUS +: BYTE_BUS];
                        end
                    end
                    if (opcode[OP_DEC_TTL] && ipv4_q) begin
                        if (ttl <= 8'd1) begin
                            cpu_d = 1'b1;
                        end else begin
                            work_d[IP_TTL*BYTE_BUS +: BYTE_BUS] = ttl - 8'd1;
                            old_ttl_d = ttl;
                            ttl_dec_d = 1'b1;
                        end
                    end
                end
            end
            ST_CSUM: begin
                hdr_out_d = work_q;
                if (ttl_dec_q) begin
                    hdr_out_d[IP_CSUM*BYTE_BUS +: 2*BYTE_BUS] = {csum_new[7:0], csum_new[15:8]};
                end
                egress_out_d = egress_q;
                drop_out_d   = drop_q;
                cpu_out_d    = drop_q ? 1'b0 : cpu_q;
                ready_d      = 1'b1;
                if (drop_q) begin
                    drop_cnt_d = drop_cnt_o + CNT_W'(1);
                end else if (hit_q) begin
                    hit_cnt_d = hit_cnt_o + CNT_W'(1);
                end else begin
                    miss_cnt_d = miss_cnt_o + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q         <= 1'b0;
            val_q         <= '0;
            work_q        <= '0;
            ipv4_q        <= 1'b0;
            egress_q      <= '0;
            drop_q        <= 1'b0;
            cpu_q         <= 1'b0;
            ttl_dec_q     <= 1'b0;
            old_ttl_q     <= '0;
            ready_o       <= 1'b0;
            pkt_hdr_o     <= '0;
            egress_port_o <= '0;
            drop_o        <= 1'b0;
            to_cpu_o      <= 1'b0;
            hit_cnt_o     <= '0;
            miss_cnt_o    <= '0;
            drop_cnt_o    <= '0;
        end else begin
            hit_q         <= hit_d;
            val_q         <= val_d;
            work_q        <= work_d;
            ipv4_q        <= ipv4_d;
            egress_q      <= egress_d;
            drop_q        <= drop_d;
            cpu_q         <= cpu_d;
            ttl_dec_q     <= ttl_dec_d;
            old_ttl_q     <= old_ttl_d;
            ready_o       <= ready_d;
            pkt_hdr_o     <= hdr_out_d;
            egress_port_o <= egress_out_d;
            drop_o        <= drop_out_d;
            to_cpu_o      <= cpu_out_d;
            hit_cnt_o     <= hit_cnt_d;
            miss_cnt_o    <= miss_cnt_d;
            drop_cnt_o    <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_flow_action_exec.sv
// Scoreboard bench for flow_action_exec: accepted transactions push a
// predicted response; a negedge monitor pops and compares on each ready_o.
module tb_flow_action_exec;
    import flow_action_exec_pkg::*;

    localparam int unsigned CW       = 4;
    localparam logic [7:0]  DEF_PORT = 8'h00;
    localparam logic        MISS_CPU = 1'b1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             is_match;
    logic [VAL_W-1:0] flow_val;
    logic [HDR_W-1:0] hdr_in;
    logic             ready;
    logic [HDR_W-1:0] hdr_out;
    logic [7:0]       egress;
    logic             drop;
    logic             to_cpu;
    logic [CW-1:0]    hit_cnt, miss_cnt, drop_cnt;

    flow_action_exec #(
        .DEFAULT_PORT (DEF_PORT),
        .MISS_TO_CPU  (MISS_CPU),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .is_match_i    (is_match),
        .flow_val_i    (flow_val),
        .pkt_hdr_i     (hdr_in),
        .ready_o       (ready),
        .pkt_hdr_o     (hdr_out),
        .egress_port_o (egress),
        .drop_o        (drop),
        .to_cpu_o      (to_cpu),
        .hit_cnt_o     (hit_cnt),
        .miss_cnt_o    (miss_cnt),
        .drop_cnt_o    (drop_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [HDR_W-1:0] hdr;
        logic [7:0]       egress;
        logic             drop;
        logic             cpu;
        int               kind;   // 0 hit, 1 miss, 2 drop
        logic [CW-1:0]    hc, mc, dc;
        int unsigned      due;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned free_at = 0;
    int unsigned m_hit = 0, m_miss = 0, m_drop = 0;

    task automatic check(input string name, input logic [HDR_W-1:0] act, input logic [HDR_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [HDR_W-1:0] rand_hdr();
        logic [HDR_W-1:0] r;
        for (int i = 0; i < HDR_MAX_LEN; i++) r[i*8 +: 8] = 8'($urandom);
        return r;
    endfunction

    function automatic logic [VAL_W-1:0] rand_val();
        logic [VAL_W-1:0] r;
        for (int i = 0; i < MAX_VAL_LEN; i++) r[i*8 +: 8] = 8'($urandom);
        return r;
    endfunction

    function automatic logic [VAL_W-1:0] mk_val(input logic [7:0] op, input logic [7:0] port,
                                                input logic [47:0] mac);
        logic [VAL_W-1:0] v;
        v = rand_val();
        v[7:0]  = op;
        v[15:8] = port;
        for (int i = 0; i < 6; i++) v[(2+i)*8 +: 8] = mac[(5-i)*8 +: 8];
        return v;
    endfunction

    function automatic logic [HDR_W-1:0] mk_hdr(input logic [15:0] etype, input logic [7:0] ttl,
                                                 input logic [7:0] proto, input logic [15:0] csum);
        logic [HDR_W-1:0] h;
        h = rand_hdr();
        h[12*8 +: 8] = etype[15:8];
        h[13*8 +: 8] = etype[7:0];
        h[22*8 +: 8] = ttl;
        h[23*8 +: 8] = proto;
        h[24*8 +: 8] = csum[15:8];
        h[25*8 +: 8] = csum[7:0];
        return h;
    endfunction

    // Reference model: applies the action rules to a byte array
    function automatic exp_t predict(input logic hit, input logic [VAL_W-1:0] val,
                                     input logic [HDR_W-1:0] hdr);
        exp_t        e;
        logic [7:0]  h[HDR_MAX_LEN];
        logic [7:0]  op;
        logic [15:0] nhc, nm, mp, res;
        int unsigned s;
        for (int i = 0; i < HDR_MAX_LEN; i++) h[i] = hdr[i*8 +: 8];
        op     = val[7:0];
        e.drop = 1'b0;
        e.cpu  = 1'b0;
        if (!hit) begin
            e.egress = DEF_PORT;
            e.cpu    = MISS_CPU;
            e.kind   = 1;
        end else begin
            e.egress = op[3] ? val[15:8] : DEF_PORT;
            if (op[2]) begin
                e.drop = 1'b1;
                e.kind = 2;
            end else begin
                e.kind = 0;
                if (op[0]) for (int i = 0; i < 6; i++) h[i] = val[(2+i)*8 +: 8];
                if (op[1] && h[12] == 8'h08 && h[13] == 8'h00) begin
                    if (h[22] < 8'd2) begin
                        e.cpu = 1'b1;
                    end else begin
                        nhc = ~{h[24], h[25]};
                        nm  = ~{h[22], h[23]};
                        mp  = {h[22] - 8'd1, h[23]};
                        s   = nhc + nm + mp;
                        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
                        res   = ~s[15:0];
                        h[22] = h[22] - 8'd1;
                        h[24] = res[15:8];
                        h[25] = res[7:0];
                    end
                end
            end
        end
        for (int i = 0; i < HDR_MAX_LEN; i++) e.hdr[i*8 +: 8] = h[i];
        return e;
    endfunction

    // Drive one start pulse; the model decides whether the DUT is free to take it
    task automatic send(input logic hit, input logic [VAL_W-1:0] val, input logic [HDR_W-1:0] hdr);
        exp_t e;
        is_match = hit;
        flow_val = val;
        hdr_in   = hdr;
        start    = 1'b1;
        if (cyc >= free_at) begin
            e = predict(hit, val, hdr);
            case (e.kind)
                0:       m_hit++;
                1:       m_miss++;
                default: m_drop++;
            endcase
            e.hc  = m_hit[CW-1:0];
            e.mc  = m_miss[CW-1:0];
            e.dc  = m_drop[CW-1:0];
            e.due = cyc + 4;
            free_at = cyc + 4;
            sb.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        is_match = 1'($urandom);
        flow_val = rand_val();
        hdr_in   = rand_hdr();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"},  ready,    0);
        check({tag, "_hdr"},    hdr_out,  0);
        check({tag, "_egress"}, egress,   0);
        check({tag, "_drop"},   drop,     0);
        check({tag, "_cpu"},    to_cpu,   0);
        check({tag, "_hit"},    hit_cnt,  0);
        check({tag, "_miss"},   miss_cnt, 0);
        check({tag, "_dcnt"},   drop_cnt, 0);
    endtask

    // Monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: ready_o=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = sb.pop_front();
                    check("latency",  cyc,      e.due);
                    check("hdr",      hdr_out,  e.hdr);
                    check("egress",   egress,   e.egress);
                    check("drop",     drop,     e.drop);
                    check("to_cpu",   to_cpu,   e.cpu);
                    check("hit_cnt",  hit_cnt,  e.hc);
                    check("miss_cnt", miss_cnt, e.mc);
                    check("drop_cnt", drop_cnt, e.dc);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_ready: no ready_o by cycle %0d, expected at %0d", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        is_match = 1'b0;
        flow_val = '0;
        hdr_in   = '0;
        idle(3);
        rst = 1'b0;
        check_reset_state("reset");

        // Hit with rewrite, TTL decrement and port select
        send(1'b1, mk_val(8'h0B, 8'h05, 48'h02_00_00_00_00_AA), mk_hdr(16'h0800, 8'h40, 8'h11, 16'hB861));
        idle(6);
        check("t1_ttl",  hdr_out[22*8 +: 8], 8'h3F);
        check("t1_csum", {hdr_out[24*8 +: 8], hdr_out[25*8 +: 8]}, 16'hB961);
        check("t1_dmac", {hdr_out[0 +: 8], hdr_out[40 +: 8]}, 16'h02AA);
        check("t1_port", egress, 8'h05);

        // Miss punted to CPU
        send(1'b0, rand_val(), mk_hdr(16'h0800, 8'h40, 8'h06, 16'h1234));
        idle(6);
        check("t2_cpu", to_cpu, 1'b1);

        // TTL expiry and drop
        send(1'b1, mk_val(8'h02, 8'h00, 48'h0), mk_hdr(16'h0800, 8'h01, 8'h11, 16'hABCD));
        idle(6);
        send(1'b1, mk_val(8'h06, 8'h09, 48'h0), mk_hdr(16'h0800, 8'h40, 8'h11, 16'hABCD));
        idle(6);

        // Non-IPv4 and checksum wrap corner
        send(1'b1, mk_val(8'h02, 8'h00, 48'h0), mk_hdr(16'h86DD, 8'h40, 8'h11, 16'h1111));
        idle(6);
        send(1'b1, mk_val(8'h02, 8'h00, 48'h0), mk_hdr(16'h0800, 8'h02, 8'h11, 16'hFEFF));
        idle(6);
        send(1'b1, mk_val(8'h0F, 8'h07, 48'h0), mk_hdr(16'h0800, 8'h00, 8'h11, 16'hFEFF));
        idle(6);

        // Start while busy is ignored; start on the ready cycle is accepted
        send(1'b1, mk_val(8'h0B, 8'h03, 48'h11_22_33_44_55_66), mk_hdr(16'h0800, 8'h80, 8'h06, 16'h0000));
        idle(1);
        send(1'b0, rand_val(), rand_hdr());
        idle(1);
        send(1'b1, mk_val(8'h08, 8'h04, 48'h0), rand_hdr());
        idle(6);

        // Reset in the middle of a transaction
        send(1'b1, mk_val(8'h0B, 8'h05, 48'h0A_0B_0C_0D_0E_0F), mk_hdr(16'h0800, 8'h40, 8'h11, 16'hB861));
        idle(1);
        rst = 1'b1;
        sb.delete();
        free_at = 0;
        m_hit   = 0;
        m_miss  = 0;
        m_drop  = 0;
        idle(2);
        rst = 1'b0;
        check_reset_state("midrst");
        send(1'b1, mk_val(8'h0B, 8'h05, 48'h02_00_00_00_00_AA), mk_hdr(16'h0800, 8'h40, 8'h11, 16'hB861));
        idle(6);

        // Back-to-back misses to wrap the 4-bit counter
        for (int i = 0; i < 18; i++) begin
            send(1'b0, rand_val(), rand_hdr());
            idle(3);
        end
        idle(4);

        // Randomized traffic with random gaps (some starts land while busy)
        for (int i = 0; i < 150; i++) begin
            logic [7:0]  op;
            logic [7:0]  ttl;
            logic [15:0] et;
            op  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
            ttl = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            et  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0800;
            send(1'($urandom_range(0, 3) != 0),
                 mk_val(op, 8'($urandom), {16'($urandom), 32'($urandom)}),
                 mk_hdr(et, ttl, 8'($urandom), 16'($urandom)));
            idle($urandom_range(0, 5));
        end

        idle(10);
        check("drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
